// File: rtl/wb_io_pkg.sv
// Shared definitions for the Wishbone IO register bank: register offsets, FSM states, reset values.
package wb_io_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEL_W  = 4;

    // Register byte offsets inside the 4 KiB window
    localparam logic [11:0] OFS_OUT_LO      = 12'h000;
    localparam logic [11:0] OFS_OUT_HI      = 12'h004;
    localparam logic [11:0] OFS_OEB_LO      = 12'h008;
    localparam logic [11:0] OFS_OEB_HI      = 12'h00C;
    localparam logic [11:0] OFS_IN_LO       = 12'h010;
    localparam logic [11:0] OFS_IN_HI       = 12'h014;
    localparam logic [11:0] OFS_IRQ_STAT_LO = 12'h018;
    localparam logic [11:0] OFS_IRQ_STAT_HI = 12'h01C;
    localparam logic [11:0] OFS_IRQ_MASK_LO = 12'h020;
    localparam logic [11:0] OFS_IRQ_MASK_HI = 12'h024;

    // Bus FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // Reset values (pads default to inputs)
    localparam logic [WORD_W-1:0] RST_OUT_WORD  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RST_OEB_WORD  = 32'hFFFF_FFFF;
    localparam logic [WORD_W-1:0] RST_STAT_WORD = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RST_MASK_WORD = 32'h0000_0000;

    // Byte-lane merge: lanes with sel set take new data, others keep old
    function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_v,
                                                     input logic [WORD_W-1:0] new_v,
                                                     input logic [SEL_W-1:0]  sel);
        logic [WORD_W-1:0] res;
        res = old_v;
        for (int k = 0; k < SEL_W; k++) begin
            if (sel[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs, plus a delay stage for rising-edge detection.
module io_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] s2,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] s1;
    logic [W-1:0] s3;

    // Synchroniser chain and edge-detect delay stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/wb_io_regbank.sv
// Wishbone classic slave: pad output/enable registers, synchronised pad readback, edge IRQ.
module wb_io_regbank
    import wb_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned NUM_IO    = 38
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic [2:0]        user_irq
);

    localparam int unsigned HI_W = NUM_IO - 32;

    state_t            state_q, state_d;
    logic              hit_c, access_c, wr_c;
    logic [11:0]       word_adr_c;
    logic [31:0]       rdata_c;
    logic              unused_adr_c;

    logic [31:0]       out_lo_q, oeb_lo_q, stat_lo_q, mask_lo_q;
    logic [HI_W-1:0]   out_hi_q, oeb_hi_q, stat_hi_q, mask_hi_q;
    logic [31:0]       clr_lo_c;
    logic [HI_W-1:0]   clr_hi_c;
    logic              irq_q;

    logic [NUM_IO-1:0] s2;
    logic [NUM_IO-1:0] rise_c;

    // Pad input synchroniser and rising-edge detector
    io_sync2 #(.W(NUM_IO)) u_sync (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .d      (io_in),
        .s2     (s2),
        .rise_c (rise_c)
    );

    assign hit_c        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign access_c     = (state_q == ST_IDLE) & hit_c;
    assign wr_c         = access_c & wbs_we_i;
    assign word_adr_c   = {wbs_adr_i[11:2], 2'b00};
    assign unused_adr_c = ^wbs_adr_i[1:0];

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: one access per IDLE->ACK->IDLE round trip
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hit_c) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // W1C clear masks, lane-gated
    always_comb begin
        clr_lo_c = '0;
        clr_hi_c = '0;
        if (wr_c && word_adr_c == OFS_IRQ_STAT_LO)
            clr_lo_c = byte_merge(32'h0, wbs_dat_i, wbs_sel_i);
        if (wr_c && word_adr_c == OFS_IRQ_STAT_HI)
            clr_hi_c = HI_W'(byte_merge(32'h0, wbs_dat_i, wbs_sel_i));
    end

    // Read data mux; unmapped offsets read 0
    always_comb begin
        rdata_c = '0;
        case (word_adr_c)
            OFS_OUT_LO:      rdata_c = out_lo_q;
            OFS_OUT_HI:      rdata_c = 32'(out_hi_q);
            OFS_OEB_LO:      rdata_c = oeb_lo_q;
            OFS_OEB_HI:      rdata_c = 32'(oeb_hi_q);
            OFS_IN_LO:       rdata_c = s2[31:0];
            OFS_IN_HI:       rdata_c = 32'(s2[NUM_IO-1:32]);
            OFS_IRQ_STAT_LO: rdata_c = stat_lo_q;
            OFS_IRQ_STAT_HI: rdata_c = 32'(stat_hi_q);
            OFS_IRQ_MASK_LO: rdata_c = mask_lo_q;
            OFS_IRQ_MASK_HI: rdata_c = 32'(mask_hi_q);
            default:         rdata_c = '0;
        endcase
    end

    // Register bank writes committed on the IDLE->ACK edge
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_lo_q  <= RST_OUT_WORD;
            out_hi_q  <= HI_W'(RST_OUT_WORD);
            oeb_lo_q  <= RST_OEB_WORD;
            oeb_hi_q  <= HI_W'(RST_OEB_WORD);
            mask_lo_q <= RST_MASK_WORD;
            mask_hi_q <= HI_W'(RST_MASK_WORD);
        end else if (wr_c) begin
            case (word_adr_c)
                OFS_OUT_LO:      out_lo_q  <= byte_merge(out_lo_q, wbs_dat_i, wbs_sel_i);
                OFS_OUT_HI:      out_hi_q  <= HI_W'(byte_merge(32'(out_hi_q), wbs_dat_i, wbs_sel_i));
                OFS_OEB_LO:      oeb_lo_q  <= byte_merge(oeb_lo_q, wbs_dat_i, wbs_sel_i);
                OFS_OEB_HI:      oeb_hi_q  <= HI_W'(byte_merge(32'(oeb_hi_q), wbs_dat_i, wbs_sel_i));
                OFS_IRQ_MASK_LO: mask_lo_q <= byte_merge(mask_lo_q, wbs_dat_i, wbs_sel_i);
                OFS_IRQ_MASK_HI: mask_hi_q <= HI_W'(byte_merge(32'(mask_hi_q), wbs_dat_i, wbs_sel_i));
                default: ;
            endcase
        end
    end

    // Sticky edge status; a new rise beats a simultaneous clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat_lo_q <= RST_STAT_WORD;
            stat_hi_q <= HI_W'(RST_STAT_WORD);
        end else begin
            stat_lo_q <= (stat_lo_q & ~clr_lo_c) | rise_c[31:0];
            stat_hi_q <= (stat_hi_q & ~clr_hi_c) | rise_c[NUM_IO-1:32];
        end
    end

    // Bus response: ack and read data live only during the ACK cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access_c;
            wbs_dat_o <= access_c ? (wbs_we_i ? 32'h0 : rdata_c) : 32'h0;
        end
    end

    // Interrupt output: any unmasked pending status
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_q <= 1'b0;
        else          irq_q <= |(stat_lo_q & mask_lo_q) | |(stat_hi_q & mask_hi_q);
    end

    assign io_out   = {out_hi_q, out_lo_q};
    assign io_oeb   = {oeb_hi_q, oeb_lo_q};
    assign user_irq = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_io_regbank.sv
// Directed self-checking bench for wb_io_regbank.
module tb_wb_io_regbank;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam int unsigned NUM_IO = 38;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = 32'h0, dat = 32'h0;
    logic              ack;
    logic [31:0]       dat_o;
    logic [NUM_IO-1:0] io_in = '0;
    logic [NUM_IO-1:0] io_out, io_oeb;
    logic [2:0]        user_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    bit          ok;
    bit          no_ack;

    wb_io_regbank #(.BASE_ADDR(BASE), .NUM_IO(NUM_IO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (user_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access: drive after a falling edge, wait (bounded) for ack, check it lasts one cycle
    task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] r);
        bit got;
        got = 0;
        r   = 32'h0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                r   = dat_o;
                got = 1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        chk("ack_seen", 64'(got), 64'd1);
        @(negedge clk);
        chk("ack_one_cycle", 64'(ack), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        chk("rst_io_out", 64'(io_out), 64'h0);
        chk("rst_user_irq", 64'(user_irq), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_dat_o", 64'(dat_o), 64'h0);

        wb_access(BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd);
        chk("in_lo_zero", 64'(rd), 64'h0);

        // Byte-lane gated write and readback
        wb_access(BASE + 32'h00, 1'b1, 32'hA5A5_A5A5, 4'b0101, rd);
        chk("io_out_lo", 64'(io_out), 64'h00_00A5_00A5);
        wb_access(BASE + 32'h00, 1'b0, 32'h0, 4'h0, rd);
        chk("out_lo_rd", 64'(rd), 64'h00A5_00A5);

        // Partial HI word
        wb_access(BASE + 32'h0C, 1'b1, 32'hFFFF_FFC0, 4'hF, rd);
        chk("io_oeb_hi", 64'(io_oeb), 64'h00_FFFF_FFFF);
        wb_access(BASE + 32'h0C, 1'b0, 32'h0, 4'h0, rd);
        chk("oeb_hi_rd", 64'(rd), 64'h0);
        wb_access(BASE + 32'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        chk("io_out_hi", 64'(io_out), 64'h3F_00A5_00A5);
        wb_access(BASE + 32'h04, 1'b0, 32'h0, 4'h0, rd);
        chk("out_hi_rd", 64'(rd), 64'h0000_003F);

        // Unmapped offset in window reads 0
        wb_access(BASE + 32'h28, 1'b0, 32'h0, 4'h0, rd);
        chk("unmapped_rd", 64'(rd), 64'h0);

        // IN_HI readback through synchroniser
        io_in[37] = 1'b1;
        repeat (3) @(negedge clk);
        wb_access(BASE + 32'h14, 1'b0, 32'h0, 4'h0, rd);
        chk("in_hi_rd", 64'(rd), 64'h0000_0020);

        // Masked rising-edge interrupt and its latency
        wb_access(BASE + 32'h20, 1'b1, 32'h0000_0001, 4'hF, rd);
        wb_access(BASE + 32'h18, 1'b0, 32'h0, 4'h0, rd);
        chk("stat_hi_bit_unrelated", 64'(rd), 64'h0);
        io_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_not_yet", 64'(user_irq), 64'h0);
        @(negedge clk);
        chk("irq_set", 64'(user_irq), 64'h1);
        wb_access(BASE + 32'h18, 1'b0, 32'h0, 4'h0, rd);
        chk("stat_lo_set", 64'(rd), 64'h1);
        wb_access(BASE + 32'h18, 1'b1, 32'h0000_0001, 4'hF, rd);
        wb_access(BASE + 32'h18, 1'b0, 32'h0, 4'h0, rd);
        chk("stat_lo_cleared", 64'(rd), 64'h0);
        chk("irq_cleared", 64'(user_irq), 64'h0);

        // Falling edge sets nothing; then W1C coinciding with a new rise
        io_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("fall_no_irq", 64'(user_irq), 64'h0);
        io_in[0] = 1'b1;
        @(negedge clk);
        wb_access(BASE + 32'h18, 1'b1, 32'h0000_0001, 4'hF, rd);
        wb_access(BASE + 32'h18, 1'b0, 32'h0, 4'h0, rd);
        chk("set_wins", 64'(rd), 64'h1);
        chk("irq_after_set_wins", 64'(user_irq), 64'h1);

        // Access outside the window is never acked
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h1000;
        no_ack = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ack !== 1'b0) no_ack = 0;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("miss_no_ack", 64'(no_ack), 64'd1);

        // Reset coinciding with the IDLE->ACK edge drops the access
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h00; dat = 32'hFFFF_FFFF; sel = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", 64'(ack), 64'h0);
        chk("rst_mid_io_out", 64'(io_out), 64'h0);
        chk("rst_mid_irq", 64'(user_irq), 64'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", 64'(ack), 64'h0);
        chk("post_rst_io_out", 64'(io_out), 64'h0);
        chk("post_rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
